// File: rtl/input_buf_sync_if.sv
// LSU-side bus for the input window: load address/funct3, store strobe/data,
// combinational load data back.
interface input_buf_sync_if;
  logic [2:0]  i_func3;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wren;
  logic [31:0] i_st_data;
  logic [31:0] o_input_buf_data;

  modport master (
    output i_func3, i_lsu_addr, i_lsu_wren, i_st_data,
    input  o_input_buf_data
  );

  modport slave (
    input  i_func3, i_lsu_addr, i_lsu_wren, i_st_data,
    output o_input_buf_data
  );
endinterface

// File: rtl/input_buf_sync.sv
// input_buf_sync: memory-mapped switch/button input window (offsets 0x00-0x1F).
// Switches and buttons are 2-flop synchronised; buttons are optionally
// debounced and raise sticky W1C press/release flags.
// Build option: INPUT_BUF_DEBOUNCE_EN enables the per-button debounce
// counters; without it the debounced level is the synchronised bit.

// One button lane: synchroniser, optional debounce, edge events that fire on
// the same edge the debounced level changes.
module input_buf_btn #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  logic s1, s2;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("input_buf_btn: DEBOUNCE_CYCLES must be >= 2");
  end

  // 2-flop synchroniser for the raw async button
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_raw;
      s2 <= s1;
    end
  end

`ifdef INPUT_BUF_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt;
  logic          lvl;
  logic          toggle;

  // toggle after DEBOUNCE_CYCLES consecutive samples disagreeing with lvl
  assign toggle = (s2 != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // debounce counter and level; any agreeing sample restarts the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (s2 == lvl) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt <= '0;
      lvl <= ~lvl;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_lvl  = lvl;
  assign o_rise = toggle & ~lvl;
  assign o_fall = toggle & lvl;
`else
  // no debounce: level is the synchronised bit, events fire as it updates
  assign o_lvl  = s2;
  assign o_rise = s1 & ~s2;
  assign o_fall = ~s1 & s2;
`endif
endmodule

module input_buf_sync #(
  parameter int SW_WIDTH        = 32,
  parameter int BTN_COUNT       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input_buf_sync_if.slave      bus,
  input  logic [SW_WIDTH-1:0]  i_io_sw,
  input  logic [BTN_COUNT-1:0] i_io_btn
);
  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  logic [BTN_COUNT-1:0] btn_lvl, btn_rise, btn_fall;
  logic [BTN_COUNT-1:0] press_flag, release_flag;
  logic [BTN_COUNT-1:0] press_clr, release_clr;
  logic [4:0]           addr;
  logic [31:0]          word, rdata;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic                 unused_bits;

  assign addr        = bus.i_lsu_addr[4:0];
  assign unused_bits = ^{bus.i_lsu_addr[31:5], bus.i_st_data};

  // 2-flop synchroniser for the switch bank
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_io_sw;
      sw_s2 <= sw_s1;
    end
  end

  input_buf_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [BTN_COUNT-1:0] (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_io_btn),
    .o_lvl  (btn_lvl),
    .o_rise (btn_rise),
    .o_fall (btn_fall)
  );

  // W1C masks; any funct3 counts, only the aligned word index is decoded
  always_comb begin
    press_clr   = '0;
    release_clr = '0;
    if (bus.i_lsu_wren && addr[4:2] == 3'd5) press_clr   = bus.i_st_data[BTN_COUNT-1:0];
    if (bus.i_lsu_wren && addr[4:2] == 3'd6) release_clr = bus.i_st_data[BTN_COUNT-1:0];
  end

  // sticky flags; a set on the same edge as a clear wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_flag   <= '0;
      release_flag <= '0;
    end else begin
      press_flag   <= (press_flag & ~press_clr) | btn_rise;
      release_flag <= (release_flag & ~release_clr) | btn_fall;
    end
  end

  // word select by aligned word index
  always_comb begin
    word = 32'h0;
    case (addr[4:2])
      3'd0:    word = 32'(sw_s2);
      3'd4:    word = 32'(btn_lvl);
      3'd5:    word = 32'(press_flag);
      3'd6:    word = 32'(release_flag);
      3'd7:    word = {16'h0, 8'(BTN_COUNT), 8'(SW_WIDTH)};
      default: word = 32'h0;
    endcase
  end

  assign byte_v = 8'(word >> {addr[1:0], 3'b000});
  assign half_v = addr[1] ? word[31:16] : word[15:0];

  // load formatting; unsupported funct3 returns zero
  always_comb begin
    rdata = 32'h0;
    case (bus.i_func3)
      3'b000:  rdata = {{24{byte_v[7]}}, byte_v};
      3'b001:  rdata = {{16{half_v[15]}}, half_v};
      3'b010:  rdata = word;
      3'b100:  rdata = {24'h0, byte_v};
      3'b101:  rdata = {16'h0, half_v};
      default: rdata = 32'h0;
    endcase
  end

  assign bus.o_input_buf_data = rdata;
endmodule

// File: tb/tb_input_buf_sync.sv
// Directed bench for input_buf_sync (DEBOUNCE_CYCLES=4, 32 switches, 4 buttons).
module tb_input_buf_sync;
`ifdef INPUT_BUF_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                         LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw;
  logic [3:0]  btn;
  int          n_chk = 0;
  int          n_fail = 0;

  input_buf_sync_if bus ();

  input_buf_sync #(.SW_WIDTH(32), .BTN_COUNT(4), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .bus      (bus),
    .i_io_sw  (sw),
    .i_io_btn (btn)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp);
    bus.i_func3    = f3;
    bus.i_lsu_addr = a;
    #1;
    chk(tag, bus.o_input_buf_data, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bus.i_func3    = f3;
    bus.i_lsu_addr = a;
    bus.i_st_data  = d;
    bus.i_lsu_wren = 1'b1;
    tick();
    bus.i_lsu_wren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw  = 32'hA1B2C3F4;
    btn = 4'h0;
    bus.i_func3 = LW; bus.i_lsu_addr = '0; bus.i_lsu_wren = 1'b0; bus.i_st_data = '0;
    repeat (2) tick();

    // reset state
    rd_chk("rst_sw",   LW, 32'h00, 32'h0);
    rd_chk("rst_lvl",  LW, 32'h10, 32'h0);
    rd_chk("rst_prs",  LW, 32'h14, 32'h0);
    rd_chk("rst_rel",  LW, 32'h18, 32'h0);
    rd_chk("rst_id",   LW, 32'h1C, 32'h00000420);

    // switch path: 2-edge latency and load formatting
    rst = 1'b0;
    tick();
    rd_chk("sw_lat1",  LW, 32'h00, 32'h0);
    tick();
    rd_chk("sw_lw",    LW,  32'h00, 32'hA1B2C3F4);
    rd_chk("sw_lb0",   LB,  32'h00, 32'hFFFFFFF4);
    rd_chk("sw_lbu3",  LBU, 32'h03, 32'h000000A1);
    rd_chk("sw_lh3",   LH,  32'h03, 32'hFFFFA1B2);
    rd_chk("sw_lhu0",  LHU, 32'h00, 32'h0000C3F4);
    rd_chk("sw_lb1",   LB,  32'h01, 32'hFFFFFFC3);
    rd_chk("sw_lw2",   LW,  32'h02, 32'hA1B2C3F4);
    rd_chk("unmapped", LBU, 32'h05, 32'h0);
    rd_chk("f3_011",   3'b011, 32'h00, 32'h0);
    rd_chk("f3_110",   3'b110, 32'h1C, 32'h0);

`ifdef INPUT_BUF_DEBOUNCE_EN
    // 3-cycle glitch never reaches the debounced level
    btn[0] = 1'b1;
    repeat (3) tick();
    btn[0] = 1'b0;
    for (int k = 0; k < 8; k++) rd_chk("glitch_lvl", LW, 32'h10, 32'h0);
    rd_chk("glitch_prs", LW, 32'h14, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      rd_chk("glitch_lvl", LW, 32'h10, 32'h0);
    end
    rd_chk("glitch_prs", LW, 32'h14, 32'h0);
`else
    // 1-cycle pulse reaches the flags 2 edges later
    btn[2] = 1'b1;
    tick();
    btn[2] = 1'b0;
    rd_chk("pulse_prs1", LW, 32'h14, 32'h0);
    tick();
    rd_chk("pulse_prs2", LW, 32'h14, 32'h4);
    tick();
    rd_chk("pulse_rel",  LW, 32'h18, 32'h4);
    wr(32'h14, 32'hF, LW);
    wr(32'h18, 32'hF, LW);
    rd_chk("pulse_clr_p", LW, 32'h14, 32'h0);
    rd_chk("pulse_clr_r", LW, 32'h18, 32'h0);
`endif

    // held press: exact latency to debounced level
    btn[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      rd_chk("hold_lvl", LW, 32'h10, (k == LAT) ? 32'h1 : 32'h0);
    end
    rd_chk("hold_prs", LW, 32'h14, 32'h1);

    btn[2] = 1'b1;
    repeat (LAT) tick();
    rd_chk("prs_0101", LW, 32'h14, 32'h5);

    // W1C bit 0; load in the clear cycle sees pre-edge flags
    bus.i_func3 = LW; bus.i_lsu_addr = 32'h14; bus.i_st_data = 32'h1; bus.i_lsu_wren = 1'b1;
    #1;
    chk("w1c_pre", bus.o_input_buf_data, 32'h5);
    tick();
    bus.i_lsu_wren = 1'b0;
    rd_chk("w1c_post", LW, 32'h14, 32'h4);
    wr(32'h20, 32'hF, LW);
    rd_chk("w1c_out", LW, 32'h14, 32'h4);

    // release flag and W1C through a byte store
    btn[0] = 1'b0;
    repeat (LAT) tick();
    rd_chk("rel_set", LW, 32'h18, 32'h1);
    rd_chk("rel_lvl", LW, 32'h10, 32'h4);
    wr(32'h18, 32'hFF, LB);
    rd_chk("rel_clr", LW, 32'h18, 32'h0);

    // set/clear collision on bit 1; bit 2 still cleared
    btn[1] = 1'b1;
    repeat (LAT - 1) tick();
    rd_chk("col_pre", LW, 32'h10, 32'h4);
    wr(32'h14, 32'h6, LW);
    rd_chk("col_prs", LW, 32'h14, 32'h2);
    rd_chk("col_lvl", LW, 32'h10, 32'h6);

    // build flags = 0xF, start a release count, then reset mid-count
    btn = 4'b1011;
    repeat (LAT) tick();
    btn[2] = 1'b1;
    repeat (LAT) tick();
    rd_chk("all_prs", LW, 32'h14, 32'hF);
    btn = 4'h0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    rd_chk("mrst_sw",  LW,  32'h00, 32'h0);
    rd_chk("mrst_lvl", LW,  32'h10, 32'h0);
    rd_chk("mrst_prs", LW,  32'h14, 32'h0);
    rd_chk("mrst_rel", LW,  32'h18, 32'h0);
    rd_chk("mrst_id",  LW,  32'h1C, 32'h00000420);
    rd_chk("mrst_idb", LBU, 32'h1D, 32'h4);
    rd_chk("mrst_ida", LB,  32'h1C, 32'h20);
    tick();
    rst = 1'b0;
    tick();
    btn[1] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      rd_chk("post_lvl", LW, 32'h10, (k == LAT) ? 32'h2 : 32'h0);
    end
    rd_chk("post_prs", LW, 32'h14, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_buf_sync.md
# input_buf_sync

Memory-mapped input peripheral for the single-cycle RISC-V LSU, serving the 32-byte input window at byte offsets 0x00–0x1F. It synchronises a parametrised switch bank into the core clock domain. It synchronises and debounces a parametrised button bank and keeps sticky write-1-to-clear press and release flags. It returns load data for all RV32I load widths, with sign or zero extension, from a combinational read path.

## Interface
Parameters:
- SW_WIDTH, 32: number of switch inputs, 1–32; zero-extended into the 32-bit switch word.
- BTN_COUNT, 4: number of buttons, 1–8.
- DEBOUNCE_CYCLES, 50000: number of consecutive stable synchronised samples required before the debounced level changes; must be ≥ 2.

Ports:
- i_clk  input  1  core clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_func3  input  3  load/store funct3.
- i_lsu_addr  input  32  byte address; only bits [4:0] are decoded.
- i_lsu_wren  input  1  store strobe for this window, sampled on the rising edge of i_clk.
- i_st_data  input  32  store data.
- i_io_sw  input  SW_WIDTH  raw, asynchronous switch inputs.
- i_io_btn  input  BTN_COUNT  raw, asynchronous button inputs, active-high.
- o_input_buf_data  output  32  load data (combinational).

## Operation
Synchronisation:
- Every i_io_sw and i_io_btn bit passes through a 2-flop synchronizer.
- The switch word is the synchronised value, zero-extended to 32 bits.

Debounce, per button:
- Each button has its own counter, ceil(log2(DEBOUNCE_CYCLES)) bits wide.
- If the synchronised bit equals the debounced level, the counter is cleared.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears on the same edge.
- A glitch shorter than DEBOUNCE_CYCLES cycles never reaches the debounced level.

Event flags:
- press_flag[i] is set on a 0→1 transition of debounced level i.
- release_flag[i] is set on a 1→0 transition of debounced level i.
- Both flags are sticky until cleared by software.

Register map (byte offsets, little-endian; unmapped bytes read 0x00):
- 0x00–0x03: switch word.
- 0x10: debounced button levels, zero-extended.
- 0x14: press flags, read / write-1-to-clear.
- 0x18: release flags, read / write-1-to-clear.
- 0x1C: constant {SW_WIDTH[7:0]} at byte 0x1C, BTN_COUNT at 0x1D, 0x00 at 0x1E–0x1F.

Address alignment:
- Byte accesses use addr[4:0].
- Halfword accesses force addr[0]=0.
- Word accesses force addr[1:0]=0.

Load formatting by i_func3:
- 000 LB: sign-extend byte.
- 001 LH: sign-extend halfword.
- 010 LW: full word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend halfword.
- Any other value: 32'h0. The output never drives z.

Stores:
- A store with i_lsu_wren=1, any funct3, to aligned word 0x14 clears press_flag[i] where i_st_data[i]=1.
- A store to aligned word 0x18 clears release_flag[i] in the same way.
- Stores to any other offset are ignored.

## Timing
Reset:
- While i_rst is high, all synchronizer flops, debounced levels, counters and flags are 0, asynchronously.
- A load from 0x00–0x18 during reset returns 0. A load from 0x1C returns the constant.

Latency:
- Raw input to switch word: 2 edges.
- Raw button to debounced level: 2 + DEBOUNCE_CYCLES edges.
- Debounced edge to flag set: same edge as the level change.
- Load data is valid in the same cycle as the address, with no wait states.

Simultaneous events:
- If a flag set and a W1C clear of the same bit occur on one edge, the set wins and the flag stays 1.
- Clears of other bits still apply.
- A load in the cycle of a clear returns the pre-edge flags.

Other boundary conditions:
- The debounce counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
- Reset asserted mid-count discards the partial count.

## Configuration
- INPUT_BUF_DEBOUNCE_EN defined: debounce counters are built as described above.
- INPUT_BUF_DEBOUNCE_EN undefined:
  - Counters are removed.
  - The debounced level equals the synchronised button bit, with 2-edge latency.
  - Flags are set on the synchronised edges.
  - The register map is unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SW_WIDTH=32, BTN_COUNT=4, with INPUT_BUF_DEBOUNCE_EN defined unless stated.
- Switch read and extension: i_io_sw=32'hA1B2C3F4, then wait 2 edges.
  - LW 0x00 → 32'hA1B2C3F4.
  - LB 0x00 → 32'hFFFFFFF4.
  - LBU 0x03 → 32'h000000A1.
  - LH 0x03 (forced to 0x02) → 32'hFFFFA1B2.
  - funct3=011 → 32'h0.
- Debounce: btn[0] pulses high for 3 cycles → 0x10 stays 0. btn[0] held high → 0x10 reads 1 exactly 6 edges after the rise, and 0x14 reads 1.
- W1C: with press flags = 4'b0101, SW 0x14 data 0x1 → 0x14 reads 0x4 next cycle. SW 0x20 (outside window) → no change.
- Set/clear collision: a W1C to bit 1 on the same edge as btn[1] becomes debounced → 0x14 bit 1 remains 1.
- Reset mid-operation: assert i_rst with a counter at 2 and flags = 0xF → all reads at 0x00–0x18 return 0. A new press still needs the full 6 edges. 0x1C reads 32'h00000420.
- With INPUT_BUF_DEBOUNCE_EN undefined: btn[2] held high for 1 cycle → 0x14 bit 2 is set 2 edges later.
